// File: rtl/minilab1_pkg.sv
// minilab1_pkg: shared parameters, FSM state type, operand ROM contents and
// the hex-digit to seven-segment decoder used by the minilab1 top level.
package minilab1_pkg;

    localparam int N          = 8;
    localparam int DATA_W     = 8;
    localparam int ACC_W      = 24;
    localparam int FIFO_DEPTH = 8;
    localparam int ROM_WORDS  = N + 1;
    localparam int ROM_AW     = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        FILL = 3'd2,
        EXEC = 3'd3,
        DONE = 3'd4
    } state_t;

    // Word r (0..7) is row r of A, word 8 is B. Byte j (j = 0 is the MSB
    // byte) of word r is 16*r + j + 1, which is simply {r, j+1} as nibbles.
    function automatic logic [63:0] rom_word(input logic [ROM_AW-1:0] addr);
        logic [63:0] w;
        w = '0;
        if (addr <= 4'd8) begin
            for (int j = 0; j < 8; j++) begin
                w[(7 - j) * 8 +: 8] = {addr, 4'(j + 1)};
            end
        end
        return w;
    endfunction

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/minilab1_fifo.sv
// byte_fifo: FIFO_DEPTH x DATA_W FIFO with a registered pop output.
// Ports: clk, rst_n (async active-low), clr (sync empty), push/push_data,
// pop, pop_data (byte popped on the previous cycle), pop_valid.
// A push when full or a pop when empty is ignored.
module byte_fifo
    import minilab1_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]    count_reg;
    logic [DATA_W-1:0] pop_data_reg;
    logic              pop_valid_reg;
    logic              do_push, do_pop;

    assign do_push = push && (count_reg != (PTR_W + 1)'(FIFO_DEPTH)) && !clr;
    assign do_pop  = pop && (count_reg != '0) && !clr;

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            pop_data_reg  <= '0;
            pop_valid_reg <= 1'b0;
        end else if (clr) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            pop_valid_reg <= 1'b0;
        end else begin
            pop_valid_reg <= do_pop;
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                pop_data_reg <= mem[rd_ptr_reg];
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign pop_data  = pop_data_reg;
    assign pop_valid = pop_valid_reg;

endmodule

// File: rtl/minilab1_mac_lane.sv
// mac_lane: one row FIFO feeding an unsigned multiply-accumulate register.
// Ports: clk, rst_n (async active-low), clr (sync clear of FIFO and acc),
// push/push_data (row byte in), pop (shared with the B FIFO), b_in (B byte
// popped in the same cycle), acc_out (ACC_W-bit running sum, wraps).
module mac_lane
    import minilab1_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic [DATA_W-1:0] b_in,
    output logic [ACC_W-1:0]  acc_out
);
    logic [DATA_W-1:0]   a_data;
    logic                a_valid;
    logic [2*DATA_W-1:0] product;
    logic [ACC_W-1:0]    acc_reg;

    byte_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (a_data),
        .pop_valid (a_valid)
    );

    // b_in is valid whenever a_valid is, since both FIFOs pop together.
    assign product = (2*DATA_W)'(a_data) * (2*DATA_W)'(b_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if (clr) begin
            acc_reg <= '0;
        end else if (a_valid) begin
            acc_reg <= acc_reg + ACC_W'(product);
        end
    end

    assign acc_out = acc_reg;

endmodule

// File: rtl/minilab1.sv
// minilab1: DE1-SoC top computing C = A*B (8x8 by 8x1 unsigned bytes).
// Ports: CLOCK_50 system clock; KEY[0] async reset (low), KEY[1] start,
// KEY[2] clear (low); SW[2:0] lane select; HEX5..HEX0 show the selected
// 24-bit result (active-low) in DONE, blank otherwise; LEDR[0] done,
// LEDR[3:1] FSM state. CLOCK2/3/4_50, KEY[3], SW[9:3] are unused.
module minilab1
    import minilab1_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic       CLOCK2_50,
    input  logic       CLOCK3_50,
    input  logic       CLOCK4_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [9:0] LEDR
);
    logic rst_n, start, clr;
    assign rst_n = KEY[0];
    assign start = KEY[1];
    assign clr   = ~KEY[2];

    logic unused_ok;
    logic b_valid_unused;
    assign unused_ok = ^{CLOCK2_50, CLOCK3_50, CLOCK4_50, KEY[3], SW[9:3], b_valid_unused};

    state_t              state_reg;
    logic [ROM_AW-1:0]   rom_addr_reg;
    logic [63:0]         rom_data_reg;
    logic [2:0]          byte_cnt_reg;
    logic [3:0]          exec_cnt_reg;
    logic [N-1:0]        push_a_reg;
    logic                push_b_reg;
    logic [DATA_W-1:0]   push_data_reg;
    logic                pop_reg;
    logic                done_reg;
    logic [DATA_W-1:0]   fill_byte;
    logic [DATA_W-1:0]   b_data;
    logic [ACC_W-1:0]    acc [N];
    logic [63:0]         rom [ROM_WORDS];

    // Operand ROM: constant contents, registered read.
    for (genvar gi = 0; gi < ROM_WORDS; gi++) begin : g_rom
        assign rom[gi] = rom_word(ROM_AW'(gi));
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            rom_data_reg <= '0;
        end else begin
            rom_data_reg <= rom[rom_addr_reg];
        end
    end

    // MSB byte first: byte_cnt 0 selects bits [63:56].
    assign fill_byte = rom_data_reg[{~byte_cnt_reg, 3'b000} +: 8];

    // Controls are registered, so each push lands one cycle after its FILL
    // cycle and each pop one cycle after its EXEC cycle. The popped bytes
    // reach the accumulators one cycle later still, hence EXEC runs 10
    // cycles: 8 pop requests plus the two-stage drain.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rom_addr_reg  <= '0;
            byte_cnt_reg  <= '0;
            exec_cnt_reg  <= '0;
            push_a_reg    <= '0;
            push_b_reg    <= 1'b0;
            push_data_reg <= '0;
            pop_reg       <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            push_a_reg <= '0;
            push_b_reg <= 1'b0;
            pop_reg    <= 1'b0;
            if (clr) begin
                state_reg    <= IDLE;
                rom_addr_reg <= '0;
                byte_cnt_reg <= '0;
                exec_cnt_reg <= '0;
                done_reg     <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            state_reg    <= READ;
                            rom_addr_reg <= '0;
                        end
                    end
                    READ: begin
                        state_reg    <= FILL;
                        byte_cnt_reg <= '0;
                    end
                    FILL: begin
                        push_data_reg <= fill_byte;
                        if (rom_addr_reg == 4'd8) begin
                            push_b_reg <= 1'b1;
                        end else begin
                            push_a_reg[rom_addr_reg[2:0]] <= 1'b1;
                        end
                        byte_cnt_reg <= byte_cnt_reg + 1'b1;
                        if (byte_cnt_reg == 3'd7) begin
                            if (rom_addr_reg == 4'd8) begin
                                state_reg    <= EXEC;
                                exec_cnt_reg <= '0;
                                rom_addr_reg <= '0;
                            end else begin
                                state_reg    <= READ;
                                rom_addr_reg <= rom_addr_reg + 1'b1;
                            end
                        end
                    end
                    EXEC: begin
                        exec_cnt_reg <= exec_cnt_reg + 1'b1;
                        pop_reg      <= (exec_cnt_reg <= 4'd7);
                        if (exec_cnt_reg == 4'd9) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                    DONE: begin
                        state_reg <= DONE;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    byte_fifo u_fifo_b (
        .clk       (CLOCK_50),
        .rst_n     (rst_n),
        .clr       (clr),
        .push      (push_b_reg),
        .push_data (push_data_reg),
        .pop       (pop_reg),
        .pop_data  (b_data),
        .pop_valid (b_valid_unused)
    );

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        mac_lane u_lane (
            .clk       (CLOCK_50),
            .rst_n     (rst_n),
            .clr       (clr),
            .push      (push_a_reg[gi]),
            .push_data (push_data_reg),
            .pop       (pop_reg),
            .b_in      (b_data),
            .acc_out   (acc[gi])
        );
    end

    // Display
    logic [ACC_W-1:0] shown;
    logic [6:0]       hex_seg [6];

    assign shown = acc[SW[2:0]];

    for (genvar gi = 0; gi < 6; gi++) begin : g_hex
        assign hex_seg[gi] = (state_reg == DONE) ? hex7seg(shown[4*gi +: 4]) : 7'h7F;
    end

    assign HEX0 = hex_seg[0];
    assign HEX1 = hex_seg[1];
    assign HEX2 = hex_seg[2];
    assign HEX3 = hex_seg[3];
    assign HEX4 = hex_seg[4];
    assign HEX5 = hex_seg[5];
    assign LEDR = {6'b0, state_reg, done_reg};

endmodule

// File: tb/tb_minilab1.sv
// tb_minilab1: directed, self-checking bench for minilab1. Expected lane
// results are computed from the ROM definition and queued; each queued entry
// is popped and compared against the seven-segment outputs.
module tb_minilab1;

    logic       clk;
    logic [3:0] key;
    logic [9:0] sw;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [9:0] ledr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          lane;
        logic [23:0] value;
    } exp_t;
    exp_t sb_q[$];

    minilab1 dut (
        .CLOCK_50  (clk),
        .CLOCK2_50 (1'b0),
        .CLOCK3_50 (1'b0),
        .CLOCK4_50 (1'b0),
        .KEY       (key),
        .SW        (sw),
        .HEX0      (hex0),
        .HEX1      (hex1),
        .HEX2      (hex2),
        .HEX3      (hex3),
        .HEX4      (hex4),
        .HEX5      (hex5),
        .LEDR      (ledr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    function automatic logic [41:0] segs_of(input logic [23:0] v);
        logic [41:0] s;
        for (int d = 0; d < 6; d++) s[7*d +: 7] = seg_of(v[4*d +: 4]);
        return s;
    endfunction

    // Row i of A is bytes 16*i+j+1, B is bytes 0x81+j.
    function automatic logic [23:0] model_lane(input int i);
        int sum = 0;
        for (int j = 0; j < 8; j++) sum += (16 * i + j + 1) * (129 + j);
        return 24'(sum);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_blank(input string tag);
        check(tag, {22'b0, hex5, hex4, hex3, hex2, hex1, hex0}, {22'b0, {6{7'h7F}}});
    endtask

    task automatic wait_state(input logic [2:0] st, input int limit, output int cycles);
        cycles = 0;
        while (ledr[3:1] !== st && cycles <= limit) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        key[1] = 1'b1;
        @(negedge clk);
        key[1] = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        key[2] = 1'b0;
        @(negedge clk);
        key[2] = 1'b1;
        #1;
    endtask

    task automatic queue_all();
        for (int i = 0; i < 8; i++) sb_q.push_back('{lane: i, value: model_lane(i)});
    endtask

    task automatic drain(input string tag);
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            sw[2:0] = 3'(e.lane);
            #1;
            check($sformatf("%s_lane%0d", tag, e.lane),
                  {22'b0, hex5, hex4, hex3, hex2, hex1, hex0}, {22'b0, segs_of(e.value)});
        end
    endtask

    int cyc;

    initial begin
        key = 4'b1100;   // reset low, start low, clr released
        sw  = '0;
        repeat (3) @(negedge clk);
        check("reset_ledr", {54'b0, ledr}, 64'h0);
        check_blank("reset_hex");
        key[0] = 1'b1;

        // Main run
        pulse_start();
        wait_state(3'd4, 150, cyc);
        check("run1_latency_ok", {63'b0, cyc <= 120}, 64'h1);
        check("run1_ledr", {54'b0, ledr}, 64'h009);
        queue_all();
        drain("run1");
        sb_q.push_back('{lane: 7, value: 24'h01E28C});
        sb_q.push_back('{lane: 0, value: 24'h0012CC});
        drain("sw_sel");

        // Start held in DONE: ignored
        @(negedge clk);
        key[1] = 1'b1;
        repeat (20) @(negedge clk);
        check("hold_start_ledr", {54'b0, ledr}, 64'h009);
        sb_q.push_back('{lane: 3, value: model_lane(3)});
        sb_q.push_back('{lane: 6, value: model_lane(6)});
        drain("hold_start");
        key[1] = 1'b0;

        // Clr from DONE, then held start reruns without doubling
        pulse_clr();
        check("clr_ledr", {54'b0, ledr}, 64'h0);
        check_blank("clr_hex");
        key[1] = 1'b1;
        wait_state(3'd4, 150, cyc);
        check("run2_latency_ok", {63'b0, cyc <= 120}, 64'h1);
        key[1] = 1'b0;
        queue_all();
        drain("run2");

        // Asynchronous reset in the middle of EXEC
        pulse_clr();
        pulse_start();
        wait_state(3'd3, 150, cyc);
        check("reach_exec", {61'b0, ledr[3:1]}, 64'h3);
        check_blank("exec_hex");
        repeat (4) @(negedge clk);
        key[0] = 1'b0;
        #1;
        check("midreset_ledr", {54'b0, ledr}, 64'h0);
        check_blank("midreset_hex");
        repeat (2) @(negedge clk);
        key[0] = 1'b1;
        pulse_start();
        wait_state(3'd4, 150, cyc);
        check("run3_latency_ok", {63'b0, cyc <= 120}, 64'h1);
        queue_all();
        drain("run3");

        // Clr and start together from IDLE: Clr wins
        pulse_clr();
        @(negedge clk);
        key[2] = 1'b0;
        key[1] = 1'b1;
        repeat (3) @(negedge clk);
        check("clr_start_ledr", {54'b0, ledr}, 64'h0);
        key[1] = 1'b0;
        key[2] = 1'b1;
        repeat (3) @(negedge clk);
        check("clr_start_idle", {54'b0, ledr}, 64'h0);
        check_blank("clr_start_hex");
        pulse_start();
        wait_state(3'd4, 150, cyc);
        check("run4_latency_ok", {63'b0, cyc <= 120}, 64'h1);
        queue_all();
        drain("run4");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
